// File: rtl/aes_pkg.sv
// rtl/aes_pkg.sv - shared AES constants: S-box table, state byte offsets, stage FSM states
package aes_pkg;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_e;

    localparam logic [7:0] SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    // Top bit of state byte s(row, col) in the column-major 128-bit state.
    function automatic int state_bit_ofs(input int row, input int col);
        return 127 - 8 * (4 * col + row);
    endfunction

endpackage

// File: rtl/aes_sbox.sv
// rtl/aes_sbox.sv - combinational forward AES S-box lookup
module aes_sbox
    import aes_pkg::*;
(
    input  logic [7:0] in_byte,
    output logic [7:0] out_byte
);

    assign out_byte = SBOX[in_byte];

endmodule

// File: rtl/aes_sub_shift.sv
// rtl/aes_sub_shift.sv - iterative SubBytes over LANES shared S-boxes, then ShiftRows wiring
module aes_sub_shift
    import aes_pkg::*;
#(
    parameter int LANES = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_state,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_state,
    output logic         busy
);

    localparam int PASSES = 16 / LANES;
    localparam int CW     = (PASSES > 1) ? $clog2(PASSES) : 1;
    localparam int GW     = 8 * LANES;
    localparam logic [CW-1:0] LAST = CW'(PASSES - 1);

    state_e        state_q, state_d;
    logic [127:0]  work_q, work_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          in_ready_q, in_ready_d;
    logic          out_valid_q, out_valid_d;
    logic          busy_q, busy_d;
    logic [GW-1:0] sub_in, sub_out;
    logic [127:0]  shifted;
    int            grp_hi;

    // Group 0 is the most significant slice, so byte s(0,0) is substituted first.
    always_comb begin
        grp_hi = 127 - GW * int'(cnt_q);
        sub_in = work_q[grp_hi -: GW];
    end

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        aes_sbox u_sbox (
            .in_byte  (sub_in[GW-1-8*i -: 8]),
            .out_byte (sub_out[GW-1-8*i -: 8])
        );
    end

    always_comb begin
        state_d = state_q;
        work_d  = work_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    work_d  = in_state;
                    cnt_d   = '0;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                work_d[grp_hi -: GW] = sub_out;
                if (cnt_q == LAST) begin
                    cnt_d   = '0;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        in_ready_d  = (state_d == IDLE);
        out_valid_d = (state_d == DONE);
        busy_d      = (state_d == BUSY);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            work_q      <= '0;
            cnt_q       <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            work_q      <= work_d;
            cnt_q       <= cnt_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
        end
    end

    // Row r of the output takes row r of the substituted state rotated left by r.
    always_comb begin
        shifted = '0;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                shifted[state_bit_ofs(r, c) -: 8] = work_q[state_bit_ofs(r, (c + r) % 4) -: 8];
            end
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign busy      = busy_q;
    assign out_state = shifted;

endmodule

// File: tb/tb_aes_sub_shift.sv
// tb/tb_aes_sub_shift.sv - scoreboard bench for aes_sub_shift with a GF(2^8) reference model
module tb_aes_sub_shift;

    localparam logic [127:0] APPB_IN  = 128'h193de3bea0f4e22b9ac68d2ae9f84808;
    localparam logic [127:0] APPB_OUT = 128'hd4bf5d30e0b452aeb84111f11e2798e5;
    localparam logic [127:0] APPB_MIX = 128'h046681e5e0cb199a48f8d37a2806264c;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [127:0] in_state = '0;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] out_state;
    logic         busy;

    logic man_ready  = 1'b1;
    logic rand_ready = 1'b0;
    logic rnd_ready  = 1'b1;
    logic sweep_go   = 1'b0;

    int tests = 0;
    int fails = 0;
    int acc_cnt = 0;
    int out_cnt = 0;
    int sweep_done = 0;

    logic [127:0] sb[$];
    logic [7:0]   ref_sbox [256];

    always #5 clk = ~clk;

    assign out_ready = rand_ready ? rnd_ready : man_ready;

    always @(posedge clk) rnd_ready <= ($urandom_range(0, 3) != 0);

    aes_sub_shift #(.LANES(4)) u_dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_state  (in_state),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_state (out_state),
        .busy      (busy)
    );

    task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] x = a;
        logic [7:0] y = b;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) p = p ^ x;
            x = x[7] ? ({x[6:0], 1'b0} ^ 8'h1b) : {x[6:0], 1'b0};
            y = {1'b0, y[7:1]};
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] v, input int k);
        logic [15:0] w = {v, v};
        return w[15-k -: 8];
    endfunction

    // Reference substitution: multiplicative inverse in GF(2^8) followed by the affine map.
    task automatic build_ref_sbox();
        for (int x = 0; x < 256; x++) begin
            logic [7:0] inv = 8'h00;
            for (int y = 1; y < 256; y++)
                if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            ref_sbox[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
        end
    endtask

    function automatic logic [127:0] model(input logic [127:0] s);
        logic [7:0] b [16];
        logic [127:0] o = '0;
        for (int i = 0; i < 16; i++) b[i] = s[127-8*i -: 8];
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                o[127-8*(4*c+r) -: 8] = ref_sbox[b[4*((c+r)%4)+r]];
        return o;
    endfunction

    function automatic logic [127:0] mix_columns(input logic [127:0] s);
        logic [127:0] o = '0;
        logic [7:0] a [4];
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) a[r] = s[127-8*(4*c+r) -: 8];
            for (int r = 0; r < 4; r++)
                o[127-8*(4*c+r) -: 8] = gmul(a[r], 8'h02) ^ gmul(a[(r+1)%4], 8'h03)
                                      ^ a[(r+2)%4] ^ a[(r+3)%4];
        end
        return o;
    endfunction

    // Monitor: every transfer must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            out_cnt++;
            if (sb.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_output: got %h with empty scoreboard", out_state);
            end else begin
                check("sb_out", out_state, sb.pop_front());
            end
        end
    end

    // Called just after a rising edge; returns just after the accept edge.
    task automatic send(input logic [127:0] s);
        int n = 0;
        in_valid = 1'b1;
        in_state = s;
        @(negedge clk);
        while (!in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            tests++;
            fails++;
            $display("FAIL send_timeout: in_ready stuck at 0 after %0d cycles", n);
        end else begin
            sb.push_back(model(s));
            acc_cnt++;
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_state = {$urandom, $urandom, $urandom, $urandom};
    endtask

    task automatic wait_out(input string nm, output int lat);
        lat = 1;
        while (!out_valid && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
        end
        if (!out_valid) begin
            tests++;
            fails++;
            $display("FAIL %s_timeout: out_valid still 0 after %0d cycles", nm, lat);
        end
    endtask

    task automatic run_const(input string nm, input logic [127:0] s, input logic [127:0] exp);
        int lat;
        send(s);
        wait_out(nm, lat);
        check(nm, out_state, exp);
        @(posedge clk);
        #1;
    endtask

    for (genvar k = 0; k < 4; k++) begin : g_sweep
        localparam int L = (k == 0) ? 1 : (k == 1) ? 2 : (k == 2) ? 8 : 16;
        logic         v = 1'b0;
        logic         ir, ov, bz;
        logic [127:0] o;

        aes_sub_shift #(.LANES(L)) u_dut (
            .clk       (clk),
            .rst       (rst),
            .in_valid  (v),
            .in_ready  (ir),
            .in_state  (APPB_IN),
            .out_valid (ov),
            .out_ready (1'b1),
            .out_state (o),
            .busy      (bz)
        );

        initial begin
            int lat;
            wait (sweep_go);
            @(posedge clk);
            #1;
            check($sformatf("sweep%0d_in_ready", L), {127'd0, ir}, 128'd1);
            v = 1'b1;
            @(posedge clk);
            #1;
            v = 1'b0;
            lat = 1;
            while (!ov && lat < 40) begin
                @(posedge clk);
                #1;
                lat++;
            end
            check($sformatf("sweep%0d_latency", L), 128'(lat), 128'(16 / L + 1));
            check($sformatf("sweep%0d_out", L), o, APPB_OUT);
            check($sformatf("sweep%0d_busy", L), {127'd0, bz}, 128'd0);
            sweep_done++;
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        logic [127:0] snap;
        int acc0, out0, n;

        build_ref_sbox();
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        check("rst_in_ready", {127'd0, in_ready}, 128'd1);
        check("rst_out_valid", {127'd0, out_valid}, 128'd0);
        check("rst_busy", {127'd0, busy}, 128'd0);
        check("rst_out_state", out_state, 128'd0);

        // Known-answer vector with latency and handshake timing.
        send(APPB_IN);
        check("appb_busy", {127'd0, busy}, 128'd1);
        check("appb_in_ready_busy", {127'd0, in_ready}, 128'd0);
        wait_out("appb", lat);
        check("appb_latency", 128'(lat), 128'd5);
        check("appb_out", out_state, APPB_OUT);
        check("appb_mix", mix_columns(out_state), APPB_MIX);
        @(posedge clk);
        #1;
        check("appb_out_valid_drop", {127'd0, out_valid}, 128'd0);
        check("appb_in_ready_back", {127'd0, in_ready}, 128'd1);

        run_const("zeros", 128'd0, {16{8'h63}});
        run_const("ones", {128{1'b1}}, {16{8'h16}});

        // Backpressure: result must hold and extra input must be ignored.
        man_ready = 1'b0;
        send({$urandom, $urandom, $urandom, $urandom});
        wait_out("bp", lat);
        snap = out_state;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            in_valid = (i == 3);
            check("bp_out_valid", {127'd0, out_valid}, 128'd1);
            check("bp_out_state", out_state, snap);
            check("bp_in_ready", {127'd0, in_ready}, 128'd0);
        end
        in_valid = 1'b0;
        man_ready = 1'b1;
        @(posedge clk);
        #1;
        check("bp_release_valid", {127'd0, out_valid}, 128'd0);
        check("bp_release_ready", {127'd0, in_ready}, 128'd1);
        repeat (20) @(posedge clk);
        #1;
        check("bp_no_ghost", {126'd0, out_valid, busy}, 128'd0);

        // Reset on the second substitution cycle discards the block.
        send({$urandom, $urandom, $urandom, $urandom});
        @(posedge clk);
        #1;
        rst = 1'b1;
        sb.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("midrst_in_ready", {127'd0, in_ready}, 128'd1);
        check("midrst_out_valid", {127'd0, out_valid}, 128'd0);
        check("midrst_out_state", out_state, 128'd0);
        check("midrst_busy", {127'd0, busy}, 128'd0);
        run_const("after_rst", APPB_IN, APPB_OUT);

        // Random regression with random output stalls.
        rand_ready = 1'b1;
        acc0 = acc_cnt;
        out0 = out_cnt;
        for (int i = 0; i < 1000; i++) begin
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #1;
            send({$urandom, $urandom, $urandom, $urandom});
        end
        n = 0;
        while (sb.size() != 0 && n < 200) begin
            @(posedge clk);
            n++;
        end
        #1;
        check("rand_drained", 128'(sb.size()), 128'd0);
        check("rand_count", 128'(out_cnt - out0), 128'(acc_cnt - acc0));
        rand_ready = 1'b0;
        man_ready = 1'b1;

        // Lane-count sweep on the known-answer vector.
        sweep_go = 1'b1;
        n = 0;
        while (sweep_done < 4 && n < 100) begin
            @(posedge clk);
            n++;
        end
        #1;
        check("sweep_done", 128'(sweep_done), 128'd4);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/aes_sub_shift.md
Name: aes_sub_shift

Overview:
- Iterative AES SubBytes followed by ShiftRows on one 128-bit state. Sits directly upstream of the combinational MixColumns stage in the round datapath and feeds it.
- Shares a configurable number of S-box lanes across the 16 state bytes over several cycles.
- Uses valid/ready handshakes on both sides so the round controller can stall the stage.

Parameters:
- LANES, 4, number of S-box instances; legal values 1, 2, 4, 8, 16; PASSES = 16/LANES cycles per block.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous reset, active-high
- in_valid  input  1  in_state holds a valid block
- in_ready  output  1  stage can accept a block
- in_state  input  128  state, column-major: [127:120]=s(0,0), [119:112]=s(1,0), ..., [7:0]=s(3,3)
- out_valid  output  1  out_state holds a valid result
- out_ready  input  1  consumer accepts the result
- out_state  output  128  ShiftRows(SubBytes(in_state)), same byte ordering
- busy  output  1  high while a block is being substituted

Behaviour:
- Reset (rst=1 at a clk edge): state goes to IDLE; in_ready=1, out_valid=0, busy=0, out_state=0, lane counter=0. Reset takes priority over every other event, including mid-BUSY and while DONE is stalled; a block in flight is discarded.
- IDLE: in_ready=1. When in_valid && in_ready at an edge, in_state is captured into a 128-bit work register, the counter is cleared, and the state goes to BUSY.
- BUSY: in_ready=0, busy=1.
  - Each cycle, byte group g (bytes 16-LANES*(g+1) .. 16-LANES*g-1 of the work register, MSB-first, i.e. byte 0 first) passes through the LANES S-boxes and is written back in place.
  - The counter increments each cycle. After pass PASSES-1, the state goes to DONE.
- DONE: out_valid=1, busy=0, in_ready=0. out_state is the work register routed through fixed ShiftRows wiring: out s(r,c) = sub s(r,(c+r) mod 4). Row 0 is unchanged; row r rotates left by r.
  - out_state is stable while out_valid && !out_ready.
  - When out_valid && out_ready, the state goes to IDLE at that edge.
  - A new input is not accepted in the same cycle; the throughput is one block per PASSES+2 cycles.
- Latency with LANES=4:
  - Accept edge T.
  - Substitution edges T+1..T+4.
  - out_valid high in the cycle after T+4.
  - With out_ready held high, in_ready is high again after edge T+5.
- in_valid while not IDLE: ignored, and in_state is not sampled. in_state is don't-care when in_valid=0.
- out_ready while out_valid=0: no effect.
- S-box: the FIPS-197 forward affine S-box, combinational, 8-bit in and out, no registers. The counter is $clog2(PASSES) bits wide (minimum 1) and wraps to 0 on the entry to DONE.
- When LANES=16, BUSY lasts exactly one cycle.
- No X propagation from the idle work register: it is cleared on reset.

Decomposition:
- Shared package aes_pkg holds:
  - the 256-entry S-box constant table (byte array);
  - the state byte-index helper (row, col) -> bit offset = 127-8*(4*col+row);
  - the FSM enum {IDLE, BUSY, DONE}.
- One sub-module is natural: aes_sbox (8-bit in, 8-bit out, table lookup from aes_pkg), instantiated LANES times via generate.
- ShiftRows is pure wiring inside this block, not a separate module.

Test Plan:
- FIPS-197 App. B round 1, LANES=4, out_ready=1: in_state=193de3bea0f4e22b9ac68d2ae9f84808 -> out_state=d4bf5d30e0b452aeb84111f11e2798e5 with out_valid high exactly 5 cycles after the accept edge. Feeding that output to mix_columns gives 046681e5e0cb199a48f8d37a2806264c.
- All-zero input -> out_state=6363...63 (16 bytes); all-FF input -> 1616...16. ShiftRows leaves both unchanged.
- Backpressure: hold out_ready=0 for 10 cycles after out_valid -> out_state and out_valid are stable, in_ready=0, and a new in_valid pulse is ignored. Raising out_ready then gives a single transfer, followed by in_ready=1.
- Reset mid-BUSY: assert rst on the 2nd substitution cycle -> next cycle in_ready=1, out_valid=0, out_state=0. A subsequent block produces a correct result with no residue from the aborted one.
- Parameter sweep LANES=1, 2, 8, 16 with the App. B vector -> identical out_state, and accept-to-out_valid latency of PASSES+1 cycles (17, 9, 3, 2).
- Random regression: 1000 random states with random out_ready stalls, checked against a software SubBytes+ShiftRows model. Every accepted block produces exactly one output, in order.
